// File: rtl/checker_pkg.sv
// ============================================================================
// Module   : checker_pkg
// Brief    : Shared types and helpers for the end-of-run register file checker
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET_DUT = 3'd1,
        ST_RUN       = 3'd2,
        ST_SCAN      = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Register-file address width; never narrower than one bit.
    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_checker.sv
// ============================================================================
// Module   : regfile_checker
// Brief    : Resets the processor, runs it for a budget or until halt, then
//            scans the GPRs against an expected-value memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_checker
    import checker_pkg::*;
#(
    parameter int NREGS         = 32,
    parameter int WIDTH         = 32,
    parameter int CNTW          = 16,
    parameter int RST_CYCLES    = 2,
    parameter int STOP_ON_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [CNTW-1:0]           run_cycles,
    input  logic                      halt,
    output logic                      dut_reset,
    output logic [addr_w(NREGS)-1:0]  rd_addr,
    input  logic [WIDTH-1:0]          rd_data,
    input  logic [WIDTH-1:0]          exp_data,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [addr_w(NREGS)-1:0]  fail_idx,
    output logic [WIDTH-1:0]          fail_act,
    output logic [WIDTH-1:0]          fail_exp,
    output logic [addr_w(NREGS):0]    err_count
);

    localparam int              AW          = addr_w(NREGS);
    localparam logic [AW-1:0]   c_last_addr = AW'(NREGS - 1);
    localparam logic [CNTW-1:0] c_rst_last  = CNTW'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
    localparam logic [AW:0]     c_err_max   = '1;

    state_t          r_state;
    logic [CNTW-1:0] r_budget;
    logic [CNTW-1:0] r_cnt;
    logic            r_issue;
    logic            r_vld;
    logic [AW-1:0]   r_cmp_addr;

    logic            r_dut_reset;
    logic [AW-1:0]   r_rd_addr;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_timeout;
    logic [AW-1:0]   r_fail_idx;
    logic [WIDTH-1:0] r_fail_act;
    logic [WIDTH-1:0] r_fail_exp;
    logic [AW:0]     r_err_count;

    logic            w_expire;
    logic            w_mismatch;
    logic            w_last_cmp;
    logic [AW:0]     w_err_inc;

    // A zero budget still gives one RUN cycle, so it expires immediately.
    assign w_expire   = (r_budget == '0) || (r_cnt == r_budget - CNTW'(1));
    // Case inequality so an unknown register value is reported, not skipped.
    assign w_mismatch = r_vld && (rd_data !== exp_data);
    assign w_last_cmp = r_vld && (r_cmp_addr == c_last_addr);
    assign w_err_inc  = (r_err_count == c_err_max) ? r_err_count : r_err_count + (AW+1)'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_budget    <= '0;
            r_cnt       <= '0;
            r_issue     <= 1'b0;
            r_vld       <= 1'b0;
            r_cmp_addr  <= '0;
            r_dut_reset <= 1'b1;
            r_rd_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= '0;
            r_fail_act  <= '0;
            r_fail_exp  <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state     <= ST_RESET_DUT;
                        r_budget    <= run_cycles;
                        r_cnt       <= '0;
                        r_issue     <= 1'b0;
                        r_vld       <= 1'b0;
                        r_dut_reset <= 1'b1;
                        r_rd_addr   <= '0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_fail_idx  <= '0;
                        r_fail_act  <= '0;
                        r_fail_exp  <= '0;
                        r_err_count <= '0;
                    end
                end
                ST_RESET_DUT: begin
                    if (r_cnt >= c_rst_last) begin
                        r_state     <= ST_RUN;
                        r_cnt       <= '0;
                        r_dut_reset <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNTW'(1);
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    // halt has priority over a budget expiring in the same cycle
                    if (halt || w_expire) begin
                        r_state   <= ST_SCAN;
                        r_timeout <= !halt;
                        r_rd_addr <= AW'(1);
                        r_issue   <= 1'b1;
                        r_vld     <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (r_issue) begin
                        r_vld      <= 1'b1;
                        r_cmp_addr <= r_rd_addr;
                        if (r_rd_addr == c_last_addr) begin
                            r_issue <= 1'b0;
                        end else begin
                            r_rd_addr <= r_rd_addr + AW'(1);
                        end
                    end else begin
                        r_vld <= 1'b0;
                    end

                    if (w_mismatch) begin
                        r_err_count <= w_err_inc;
                        if (r_err_count == '0) begin
                            r_fail_idx <= r_cmp_addr;
                            r_fail_act <= rd_data;
                            r_fail_exp <= exp_data;
                        end
                    end

                    if (w_mismatch && (STOP_ON_FIRST != 0)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                        r_issue <= 1'b0;
                        r_vld   <= 1'b0;
                    end else if (w_last_cmp) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= !w_mismatch && (r_err_count == '0) && !r_timeout;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_dut_reset <= 1'b1;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign dut_reset = r_dut_reset;
    assign rd_addr   = r_rd_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign fail_idx  = r_fail_idx;
    assign fail_act  = r_fail_act;
    assign fail_exp  = r_fail_exp;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_regfile_checker.sv
// ============================================================================
// Module   : tb_regfile_checker
// Brief    : Directed bench for three checker instances (stop-on-first,
//            full scan, and an 8 x 16-bit register file) sharing stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_checker;

    typedef struct {
        logic [15:0] rc;
        int          halt_at;
        int          inject;
        logic [31:0] mask;
        int          run_len;
        logic        timeout;
        logic        pass;
        int          err_a;
        int          idx_a;
        int          scan_a;
        int          err_b;
        int          idx_b;
        int          err_s;
        int          idx_s;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] run_cycles;
    logic        halt;

    logic        dut_reset_a, busy_a, done_a, pass_a, timeout_a;
    logic [4:0]  rd_addr_a, fail_idx_a;
    logic [31:0] rd_data_a, exp_data_a, fail_act_a, fail_exp_a;
    logic [5:0]  err_a;

    logic        dut_reset_b, busy_b, done_b, pass_b, timeout_b;
    logic [4:0]  rd_addr_b, fail_idx_b;
    logic [31:0] rd_data_b, exp_data_b, fail_act_b, fail_exp_b;
    logic [5:0]  err_b;

    logic        dut_reset_s, busy_s, done_s, pass_s, timeout_s;
    logic [2:0]  rd_addr_s, fail_idx_s;
    logic [15:0] rd_data_s, exp_data_s, fail_act_s, fail_exp_s;
    logic [3:0]  err_s;

    logic [31:0] gpr   [32];
    logic [31:0] expm  [32];
    logic [15:0] gpr_s [8];
    logic [15:0] exp_s [8];

    int n_tests = 0;
    int n_fail  = 0;
    int m_rst, m_run, m_scan_a, m_scan_b, m_scan_s;
    logic [31:0] seen_b;
    logic [7:0]  seen_s;
    vec_t vecs [9];

    regfile_checker #(.NREGS(32), .WIDTH(32), .CNTW(16), .RST_CYCLES(2), .STOP_ON_FIRST(1)) u_stop (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .halt(halt),
        .dut_reset(dut_reset_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .exp_data(exp_data_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a), .fail_idx(fail_idx_a),
        .fail_act(fail_act_a), .fail_exp(fail_exp_a), .err_count(err_a)
    );

    regfile_checker #(.NREGS(32), .WIDTH(32), .CNTW(16), .RST_CYCLES(2), .STOP_ON_FIRST(0)) u_all (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .halt(halt),
        .dut_reset(dut_reset_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .exp_data(exp_data_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .fail_idx(fail_idx_b),
        .fail_act(fail_act_b), .fail_exp(fail_exp_b), .err_count(err_b)
    );

    regfile_checker #(.NREGS(8), .WIDTH(16), .CNTW(16), .RST_CYCLES(2), .STOP_ON_FIRST(0)) u_small (
        .clk(clk), .reset(reset), .start(start), .run_cycles(run_cycles), .halt(halt),
        .dut_reset(dut_reset_s), .rd_addr(rd_addr_s), .rd_data(rd_data_s), .exp_data(exp_data_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .timeout(timeout_s), .fail_idx(fail_idx_s),
        .fail_act(fail_act_s), .fail_exp(fail_exp_s), .err_count(err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and expected memory: one-cycle synchronous reads.
    always @(posedge clk) begin
        rd_data_a  <= gpr[rd_addr_a];
        exp_data_a <= expm[rd_addr_a];
        rd_data_b  <= gpr[rd_addr_b];
        exp_data_b <= expm[rd_addr_b];
        rd_data_s  <= gpr_s[rd_addr_s];
        exp_data_s <= exp_s[rd_addr_s];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected value of register i is i+3; a masked register holds a marker.
    // Register 0 always disagrees with memory; it must never be compared.
    task automatic load_mem(input logic [31:0] mask);
        for (int i = 0; i < 32; i++) begin
            expm[i] = 32'(i + 3);
            gpr[i]  = mask[i] ? 32'hcafebabe : 32'(i + 3);
        end
        gpr[0] = 32'hdead0000;
        for (int i = 0; i < 8; i++) begin
            exp_s[i] = 16'(i + 3);
            gpr_s[i] = mask[i] ? 16'hbeef : 16'(i + 3);
        end
        gpr_s[0] = 16'hdead;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   cyc;
        logic in_run;
        load_mem(v.mask);
        @(negedge clk);
        run_cycles = v.rc;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        run_cycles = '0;
        m_rst = 0; m_run = 0; m_scan_a = 0; m_scan_b = 0; m_scan_s = 0;
        seen_b = '0; seen_s = '0;
        cyc = 0;
        while (cyc < 3000) begin
            in_run = busy_b && !dut_reset_b && (rd_addr_b == 5'd0);
            if (busy_b && dut_reset_b) m_rst++;
            if (in_run) m_run++;
            if (busy_a && rd_addr_a != 5'd0) m_scan_a++;
            if (busy_b && rd_addr_b != 5'd0) begin
                m_scan_b++;
                seen_b[rd_addr_b] = 1'b1;
            end
            if (busy_s && rd_addr_s != 3'd0) begin
                m_scan_s++;
                seen_s[rd_addr_s] = 1'b1;
            end
            if (done_a && done_b && done_s) break;
            halt       = in_run && (v.halt_at != 0) && (m_run == v.halt_at);
            start      = in_run && (v.inject != 0) && (m_run == v.inject);
            run_cycles = start ? 16'd30 : 16'd0;
            @(negedge clk);
            cyc++;
        end
        halt  = 1'b0;
        start = 1'b0;
        chk($sformatf("v%0d_wait_done", id), 64'(cyc < 3000), 64'd1);
        chk($sformatf("v%0d_rst_len", id), 64'(m_rst), 64'd2);
        chk($sformatf("v%0d_run_len", id), 64'(m_run), 64'(v.run_len));
        chk($sformatf("v%0d_timeout_a", id), 64'(timeout_a), 64'(v.timeout));
        chk($sformatf("v%0d_timeout_b", id), 64'(timeout_b), 64'(v.timeout));
        chk($sformatf("v%0d_timeout_s", id), 64'(timeout_s), 64'(v.timeout));
        chk($sformatf("v%0d_pass_a", id), 64'(pass_a), 64'(v.pass));
        chk($sformatf("v%0d_pass_b", id), 64'(pass_b), 64'(v.pass));
        chk($sformatf("v%0d_pass_s", id), 64'(pass_s), 64'(v.pass));
        chk($sformatf("v%0d_err_a", id), 64'(err_a), 64'(v.err_a));
        chk($sformatf("v%0d_err_b", id), 64'(err_b), 64'(v.err_b));
        chk($sformatf("v%0d_err_s", id), 64'(err_s), 64'(v.err_s));
        chk($sformatf("v%0d_idx_a", id), 64'(fail_idx_a), 64'(v.idx_a));
        chk($sformatf("v%0d_idx_b", id), 64'(fail_idx_b), 64'(v.idx_b));
        chk($sformatf("v%0d_idx_s", id), 64'(fail_idx_s), 64'(v.idx_s));
        chk($sformatf("v%0d_act_a", id), 64'(fail_act_a), (v.err_a != 0) ? 64'hcafebabe : 64'd0);
        chk($sformatf("v%0d_exp_a", id), 64'(fail_exp_a), (v.err_a != 0) ? 64'(v.idx_a + 3) : 64'd0);
        chk($sformatf("v%0d_act_b", id), 64'(fail_act_b), (v.err_b != 0) ? 64'hcafebabe : 64'd0);
        chk($sformatf("v%0d_exp_b", id), 64'(fail_exp_b), (v.err_b != 0) ? 64'(v.idx_b + 3) : 64'd0);
        chk($sformatf("v%0d_act_s", id), 64'(fail_act_s), (v.err_s != 0) ? 64'hbeef : 64'd0);
        chk($sformatf("v%0d_scan_a", id), 64'(m_scan_a), 64'(v.scan_a));
        chk($sformatf("v%0d_scan_b", id), 64'(m_scan_b), 64'd32);
        chk($sformatf("v%0d_scan_s", id), 64'(m_scan_s), 64'd8);
        chk($sformatf("v%0d_seen_b", id), 64'(seen_b), 64'hfffffffe);
        chk($sformatf("v%0d_seen_s", id), 64'(seen_s), 64'hfe);
        chk($sformatf("v%0d_dutrst_b", id), 64'(dut_reset_b), 64'd0);
    endtask

    initial begin
        int cyc;
        //            rc     halt inj mask           run to pass eA iA sA  eB iB eS iS
        vecs[0] = '{16'd16, 0,  0, 32'h00000000, 16, 1, 0,   0, 0, 32, 0, 0, 0, 0};
        vecs[1] = '{16'd16, 10, 0, 32'h00000000, 10, 0, 1,   0, 0, 32, 0, 0, 0, 0};
        vecs[2] = '{16'd20, 4,  0, 32'h00000020, 4,  0, 0,   1, 5, 6,  1, 5, 1, 5};
        vecs[3] = '{16'd20, 4,  0, 32'h80000088, 4,  0, 0,   1, 3, 4,  3, 3, 2, 3};
        vecs[4] = '{16'd5,  5,  0, 32'h00000000, 5,  0, 1,   0, 0, 32, 0, 0, 0, 0};
        vecs[5] = '{16'd0,  0,  0, 32'h00000000, 1,  1, 0,   0, 0, 32, 0, 0, 0, 0};
        vecs[6] = '{16'd0,  1,  0, 32'h00000000, 1,  0, 1,   0, 0, 32, 0, 0, 0, 0};
        vecs[7] = '{16'd3,  2,  0, 32'h000000fe, 2,  0, 0,   1, 1, 2,  7, 1, 7, 1};
        vecs[8] = '{16'd10, 0,  3, 32'h00000000, 10, 1, 0,   0, 0, 32, 0, 0, 0, 0};

        reset = 1'b0; start = 1'b0; halt = 1'b0; run_cycles = '0;
        load_mem('0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_dut_reset", 64'(dut_reset_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_pass", 64'(pass_a), 64'd0);
        chk("rst_timeout", 64'(timeout_a), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_fail_idx", 64'(fail_idx_a), 64'd0);
        chk("rst_fail_act", 64'(fail_act_a), 64'd0);
        @(negedge clk);
        chk("idle_hold_busy", 64'(busy_b), 64'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Reset pulled low in the middle of a scan abandons the run.
        load_mem(32'h00000008);
        @(negedge clk);
        run_cycles = 16'd4;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc = 0;
        while (rd_addr_b != 5'd10 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        chk("scanrst_reach", 64'(cyc < 300), 64'd1);
        chk("scanrst_pre_busy", 64'(busy_b), 64'd1);
        chk("scanrst_pre_err", 64'(err_b), 64'd1);
        chk("scanrst_pre_timeout", 64'(timeout_b), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("scanrst_dut_reset", 64'(dut_reset_b), 64'd1);
        chk("scanrst_busy", 64'(busy_b), 64'd0);
        chk("scanrst_done", 64'(done_b), 64'd0);
        chk("scanrst_pass", 64'(pass_b), 64'd0);
        chk("scanrst_timeout", 64'(timeout_b), 64'd0);
        chk("scanrst_rd_addr", 64'(rd_addr_b), 64'd0);
        chk("scanrst_err", 64'(err_b), 64'd0);
        chk("scanrst_fail_idx", 64'(fail_idx_b), 64'd0);
        chk("scanrst_fail_act", 64'(fail_act_b), 64'd0);
        chk("scanrst_fail_exp", 64'(fail_exp_b), 64'd0);
        chk("scanrst_done_a", 64'(done_a), 64'd0);
        @(negedge clk);
        chk("scanrst_stay_idle", 64'(busy_b), 64'd0);

        run_vec(vecs[1], 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
